// File: rtl/vram_write_arbiter.sv
// Shares the single VRAM port between GPU fetches and a small queue of CPU writes.
// GPU fetches win unless a queued write has waited STARVE_LIMIT-1 arbitrations.
module vram_write_arbiter #(
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                     gpu_clk,
  input  logic                     rst,
  input  logic                     wr_valid_i,
  output logic                     wr_ready_o,
  input  logic [11:0]              wr_address_i,
  input  logic [7:0]               wr_data_i,
  input  logic                     gpu_req_i,
  input  logic [11:0]              gpu_address_i,
  output logic [11:0]              vram_address_o,
  output logic [7:0]               vram_data_o,
  output logic                     vram_wen_o,
  output logic                     gpu_grant_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     overflow_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int SW = $clog2(STARVE_LIMIT) + 1;
  localparam logic [SW-1:0] FORCE_AT = SW'(STARVE_LIMIT - 1);

  typedef enum logic [1:0] {IDLE, PENDING, FORCED} state_t;

  typedef struct packed {
    logic [11:0] address;
    logic [7:0]  data;
  } entry_t;

  entry_t          mem [DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [SW-1:0]   starve_cnt, starve_next;
  logic [CW-1:0]   count_next;
  state_t          state, state_next;
  logic            push, pop, grant;

  assign wr_ready_o = (count_o < CW'(DEPTH));
  assign push       = wr_valid_i && wr_ready_o;
  assign pop        = (state == FORCED) || ((state == PENDING) && !gpu_req_i);
  assign grant      = gpu_req_i && (state != FORCED);

  // State lags the queue by one edge, so an entry pushed at edge n is first
  // seen as PENDING in the cycle after n; this is what prevents a bypass.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    count_next  = count_o;
    starve_next = starve_cnt;
    state_next  = state;
    if (push && !pop)
      count_next = count_o + CW'(1);
    else if (pop && !push)
      count_next = count_o - CW'(1);

    if (pop) begin
      starve_next = '0;
      if (count_next == '0)
        state_next = IDLE;
      else
        state_next = (starve_next == FORCE_AT) ? FORCED : PENDING;
    end else if (state == PENDING) begin
      starve_next = starve_cnt + SW'(1);
      state_next  = (starve_next == FORCE_AT) ? FORCED : PENDING;
    end else if (state == IDLE) begin
      starve_next = '0;
      if (count_o != '0)
        state_next = (starve_next == FORCE_AT) ? FORCED : PENDING;
    end
  end

  // NOTE: queue storage is deliberately not reset; the pointers and count define validity.
  always_ff @(posedge gpu_clk) begin
    if (!rst && push)
      mem[wr_ptr] <= '{address: wr_address_i, data: wr_data_i};
  end

  always_ff @(posedge gpu_clk) begin
    if (rst) begin
      state          <= IDLE;
      starve_cnt     <= '0;
      count_o        <= '0;
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      overflow_o     <= 1'b0;
      vram_address_o <= '0;
      vram_data_o    <= '0;
      vram_wen_o     <= 1'b0;
      gpu_grant_o    <= 1'b0;
    end else begin
      state      <= state_next;
      starve_cnt <= starve_next;
      count_o    <= count_next;
      if (push)
        wr_ptr <= wr_ptr + AW'(1);
      if (pop)
        rd_ptr <= rd_ptr + AW'(1);
      if (wr_valid_i && !wr_ready_o)
        overflow_o <= 1'b1;

      vram_wen_o  <= pop;
      gpu_grant_o <= grant;
      if (pop) begin
        vram_address_o <= mem[rd_ptr].address;
        vram_data_o    <= mem[rd_ptr].data;
      end else if (grant) begin
        vram_address_o <= gpu_address_i;
      end
    end
  end

endmodule

// File: tb/tb_vram_write_arbiter.sv
// Directed bench for vram_write_arbiter: reset, single write latency, starvation
// forcing, overflow, pointer wrap with simultaneous push/pop, and reset flush.
module tb_vram_write_arbiter;

  logic        gpu_clk;
  logic        rst;
  logic        wr_valid_i;
  logic        wr_ready_o;
  logic [11:0] wr_address_i;
  logic [7:0]  wr_data_i;
  logic        gpu_req_i;
  logic [11:0] gpu_address_i;
  logic [11:0] vram_address_o;
  logic [7:0]  vram_data_o;
  logic        vram_wen_o;
  logic        gpu_grant_o;
  logic [2:0]  count_o;
  logic        overflow_o;

  int checks   = 0;
  int failures = 0;

  vram_write_arbiter #(.DEPTH(4), .STARVE_LIMIT(8)) dut (
    .gpu_clk        (gpu_clk),
    .rst            (rst),
    .wr_valid_i     (wr_valid_i),
    .wr_ready_o     (wr_ready_o),
    .wr_address_i   (wr_address_i),
    .wr_data_i      (wr_data_i),
    .gpu_req_i      (gpu_req_i),
    .gpu_address_i  (gpu_address_i),
    .vram_address_o (vram_address_o),
    .vram_data_o    (vram_data_o),
    .vram_wen_o     (vram_wen_o),
    .gpu_grant_o    (gpu_grant_o),
    .count_o        (count_o),
    .overflow_o     (overflow_o)
  );

  initial begin
    gpu_clk = 1'b0;
    forever #5 gpu_clk = ~gpu_clk;
  end

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic tick();
    @(posedge gpu_clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; wr_valid_i = 1'b0; wr_address_i = '0; wr_data_i = '0;
    gpu_req_i = 1'b0; gpu_address_i = '0;
    tick(); tick();
    rst = 1'b0;
    checks++;
    if (count_o !== 3'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", count_o); end
    checks++;
    if (wr_ready_o !== 1'b1 || overflow_o !== 1'b0) begin
      failures++; $display("FAIL reset_flags ready=%0b overflow=%0b exp ready=1 overflow=0", wr_ready_o, overflow_o);
    end
    checks++;
    if ({vram_wen_o, gpu_grant_o, vram_address_o, vram_data_o} !== 22'd0) begin
      failures++; $display("FAIL reset_vram wen=%0b grant=%0b addr=%h data=%h exp all zero",
                           vram_wen_o, gpu_grant_o, vram_address_o, vram_data_o);
    end
  endtask

  task automatic test_single_write();
    gpu_req_i = 1'b0;
    wr_valid_i = 1'b1; wr_address_i = 12'h123; wr_data_i = 8'hAB;
    tick();                                            // edge 0: push
    wr_valid_i = 1'b0;
    checks++;
    if (count_o !== 3'd1 || vram_wen_o !== 1'b0) begin
      failures++; $display("FAIL single_e0 count=%0d wen=%0b exp count=1 wen=0", count_o, vram_wen_o);
    end
    tick();                                            // edge 1: no bypass
    checks++;
    if (vram_wen_o !== 1'b0) begin failures++; $display("FAIL single_e1_nobypass wen=%0b exp 0", vram_wen_o); end
    tick();                                            // edge 2: write lands
    checks++;
    if ({vram_wen_o, gpu_grant_o, vram_address_o, vram_data_o} !== {1'b1, 1'b0, 12'h123, 8'hAB}) begin
      failures++; $display("FAIL single_e2 wen=%0b grant=%0b addr=%h data=%h exp wen=1 grant=0 addr=123 data=ab",
                           vram_wen_o, gpu_grant_o, vram_address_o, vram_data_o);
    end
    checks++;
    if (count_o !== 3'd0) begin failures++; $display("FAIL single_count got=%0d exp=0", count_o); end
    tick();                                            // idle, no request: address/data hold
    checks++;
    if ({vram_wen_o, gpu_grant_o, vram_address_o, vram_data_o} !== {1'b0, 1'b0, 12'h123, 8'hAB}) begin
      failures++; $display("FAIL idle_hold wen=%0b grant=%0b addr=%h data=%h exp wen=0 grant=0 addr=123 data=ab",
                           vram_wen_o, gpu_grant_o, vram_address_o, vram_data_o);
    end
  endtask

  task automatic test_starve();
    gpu_req_i = 1'b1; gpu_address_i = 12'h3C0;
    wr_valid_i = 1'b1; wr_address_i = 12'h456; wr_data_i = 8'h5A;
    tick();                                            // edge 0: push, IDLE grant
    wr_valid_i = 1'b0;
    checks++;
    if (gpu_grant_o !== 1'b1 || vram_address_o !== 12'h3C0) begin
      failures++; $display("FAIL starve_e0 grant=%0b addr=%h exp grant=1 addr=3c0", gpu_grant_o, vram_address_o);
    end
    // edge 1 from the IDLE arbitration, edges 2..8 from 7 PENDING arbitrations
    for (int k = 1; k <= 8; k++) begin
      tick();
      checks++;
      if ({gpu_grant_o, vram_wen_o, vram_address_o} !== {1'b1, 1'b0, 12'h3C0}) begin
        failures++; $display("FAIL starve_grant_e%0d grant=%0b wen=%0b addr=%h exp grant=1 wen=0 addr=3c0",
                             k, gpu_grant_o, vram_wen_o, vram_address_o);
      end
    end
    tick();                                            // edge 9: forced write
    checks++;
    if ({gpu_grant_o, vram_wen_o, vram_address_o, vram_data_o} !== {1'b0, 1'b1, 12'h456, 8'h5A}) begin
      failures++; $display("FAIL starve_forced grant=%0b wen=%0b addr=%h data=%h exp grant=0 wen=1 addr=456 data=5a",
                           gpu_grant_o, vram_wen_o, vram_address_o, vram_data_o);
    end
    tick();                                            // edge 10: grants resume
    checks++;
    if ({gpu_grant_o, vram_wen_o, vram_address_o} !== {1'b1, 1'b0, 12'h3C0}) begin
      failures++; $display("FAIL starve_resume grant=%0b wen=%0b addr=%h exp grant=1 wen=0 addr=3c0",
                           gpu_grant_o, vram_wen_o, vram_address_o);
    end
    gpu_req_i = 1'b0;
    tick();
    checks++;
    if (gpu_grant_o !== 1'b0 || count_o !== 3'd0) begin
      failures++; $display("FAIL starve_idle grant=%0b count=%0d exp grant=0 count=0", gpu_grant_o, count_o);
    end
  endtask

  task automatic test_overflow();
    gpu_req_i = 1'b1; gpu_address_i = 12'h0F0;
    for (int i = 0; i < 5; i++) begin
      wr_valid_i = 1'b1; wr_address_i = 12'h100 + 12'(i); wr_data_i = 8'h10 + 8'(i);
      checks++;
      if (wr_ready_o !== (i < 4)) begin
        failures++; $display("FAIL ovf_ready_%0d got=%0b exp=%0b", i, wr_ready_o, (i < 4));
      end
      tick();
      checks++;
      if (overflow_o !== (i == 4)) begin
        failures++; $display("FAIL ovf_flag_%0d got=%0b exp=%0b", i, overflow_o, (i == 4));
      end
    end
    wr_valid_i = 1'b0;
    checks++;
    if (count_o !== 3'd4 || wr_ready_o !== 1'b0) begin
      failures++; $display("FAIL ovf_full count=%0d ready=%0b exp count=4 ready=0", count_o, wr_ready_o);
    end
    gpu_req_i = 1'b0;
    for (int j = 0; j < 4; j++) begin
      tick();
      checks++;
      if ({vram_wen_o, vram_address_o, vram_data_o} !== {1'b1, 12'h100 + 12'(j), 8'h10 + 8'(j)}) begin
        failures++; $display("FAIL ovf_drain_%0d wen=%0b addr=%h data=%h exp wen=1 addr=%h data=%h",
                             j, vram_wen_o, vram_address_o, vram_data_o, 12'h100 + 12'(j), 8'h10 + 8'(j));
      end
    end
    tick();
    checks++;
    if ({vram_wen_o, count_o, overflow_o} !== {1'b0, 3'd0, 1'b1}) begin
      failures++; $display("FAIL ovf_after wen=%0b count=%0d overflow=%0b exp wen=0 count=0 overflow=1",
                           vram_wen_o, count_o, overflow_o);
    end
  endtask

  task automatic test_wrap();
    logic [11:0] exp_addr  [5] = '{12'h200, 12'h201, 12'h202, 12'h203, 12'h204};
    logic [2:0]  exp_count [5] = '{3'd2, 3'd2, 3'd2, 3'd1, 3'd0};
    gpu_req_i = 1'b1; gpu_address_i = 12'h0AA;
    for (int i = 0; i < 3; i++) begin
      wr_valid_i = 1'b1; wr_address_i = 12'h200 + 12'(i); wr_data_i = 8'hA0 + 8'(i);
      tick();
    end
    gpu_req_i = 1'b0;
    for (int k = 0; k < 5; k++) begin
      wr_valid_i = (k == 1 || k == 2);
      wr_address_i = 12'h202 + 12'(k);
      wr_data_i = 8'hA2 + 8'(k);
      tick();
      checks++;
      if ({vram_wen_o, vram_address_o, vram_data_o, count_o} !==
          {1'b1, exp_addr[k], 8'hA0 + 8'(k), exp_count[k]}) begin
        failures++; $display("FAIL wrap_%0d wen=%0b addr=%h data=%h count=%0d exp wen=1 addr=%h data=%h count=%0d",
                             k, vram_wen_o, vram_address_o, vram_data_o, count_o,
                             exp_addr[k], 8'hA0 + 8'(k), exp_count[k]);
      end
    end
    wr_valid_i = 1'b0;
    tick();
    checks++;
    if (vram_wen_o !== 1'b0) begin failures++; $display("FAIL wrap_idle wen=%0b exp 0", vram_wen_o); end
  endtask

  task automatic test_rst_flush();
    gpu_req_i = 1'b1; gpu_address_i = 12'h055;
    for (int i = 0; i < 3; i++) begin
      wr_valid_i = 1'b1; wr_address_i = 12'h300 + 12'(i); wr_data_i = 8'hC0 + 8'(i);
      tick();
    end
    checks++;
    if (count_o !== 3'd3) begin failures++; $display("FAIL flush_pre_count got=%0d exp=3", count_o); end
    rst = 1'b1; gpu_req_i = 1'b0;
    wr_valid_i = 1'b1; wr_address_i = 12'h3FF; wr_data_i = 8'hFF;
    tick();
    rst = 1'b0; wr_valid_i = 1'b0;
    checks++;
    if ({count_o, wr_ready_o, overflow_o} !== {3'd0, 1'b1, 1'b0}) begin
      failures++; $display("FAIL flush_state count=%0d ready=%0b overflow=%0b exp count=0 ready=1 overflow=0",
                           count_o, wr_ready_o, overflow_o);
    end
    checks++;
    if ({vram_wen_o, gpu_grant_o, vram_address_o, vram_data_o} !== 22'd0) begin
      failures++; $display("FAIL flush_vram wen=%0b grant=%0b addr=%h data=%h exp all zero",
                           vram_wen_o, gpu_grant_o, vram_address_o, vram_data_o);
    end
    for (int k = 0; k < 10; k++) begin
      tick();
      checks++;
      if (vram_wen_o !== 1'b0 || count_o !== 3'd0) begin
        failures++; $display("FAIL flush_stale_%0d wen=%0b count=%0d exp wen=0 count=0", k, vram_wen_o, count_o);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_starve();
    test_overflow();
    test_wrap();
    test_rst_flush();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vram_write_arbiter.md
VRAM_WRITE_ARBITER -- requirements
Module: vram_write_arbiter

Interface
REQ-001 SHALL have parameter DEPTH, default 4, write-queue entries; power of two, >= 2.
REQ-002 SHALL have parameter STARVE_LIMIT, default 8, max consecutive cycles a pending write waits behind GPU fetches.
REQ-003 SHALL have port gpu_clk  input  1  sole clock; all logic on rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port wr_valid_i  input  1  CPU VRAM write request, already in gpu_clk domain.
REQ-006 SHALL have port wr_ready_o  output  1  queue can accept a write this cycle.
REQ-007 SHALL have port wr_address_i  input  12  VRAM offset (mapache64::vram_address_t).
REQ-008 SHALL have port wr_data_i  input  8  write data (mapache64::data_t).
REQ-009 SHALL have port gpu_req_i  input  1  GPU needs the VRAM port for a fetch.
REQ-010 SHALL have port gpu_address_i  input  12  GPU fetch address.
REQ-011 SHALL have port vram_address_o  output  12  registered VRAM port address.
REQ-012 SHALL have port vram_data_o  output  8  registered VRAM write data.
REQ-013 SHALL have port vram_wen_o  output  1  registered VRAM write enable.
REQ-014 SHALL have port gpu_grant_o  output  1  registered; vram_address_o currently carries the GPU fetch.
REQ-015 SHALL have port count_o  output  $clog2(DEPTH)+1  queue occupancy.
REQ-016 SHALL have port overflow_o  output  1  sticky: a write was dropped.

Function
REQ-017 SHALL push {wr_address_i, wr_data_i} when wr_valid_i && wr_ready_o; wr_ready_o = (count_o < DEPTH), from registered count only.
REQ-018 SHALL drop wr_valid_i while wr_ready_o=0 and set overflow_o at the next edge; overflow_o holds until rst.
REQ-019 SHALL keep FIFO order; read/write pointers wrap modulo DEPTH.
REQ-020 SHALL arbitrate once per cycle, result registered onto vram_* and gpu_grant_o at the next edge (1-cycle latency).
REQ-021 SHALL use states IDLE (queue empty), PENDING (non-empty, starve count < STARVE_LIMIT-1), FORCED (starve count = STARVE_LIMIT-1).
REQ-022 SHALL, in IDLE or PENDING with gpu_req_i=1: register gpu_address_i, gpu_grant_o=1, vram_wen_o=0, no pop.
REQ-023 SHALL, in PENDING with gpu_req_i=0, or in FORCED regardless of gpu_req_i: pop head, register its address/data, vram_wen_o=1, gpu_grant_o=0.
REQ-024 SHALL, in IDLE with gpu_req_i=0: vram_wen_o=0, gpu_grant_o=0, vram_address_o/vram_data_o hold previous values.
REQ-025 SHALL increment the starve counter each PENDING cycle without a pop; clear it on every pop and in IDLE.
REQ-026 SHALL not bypass: a write pushed at edge n is poppable no earlier than the arbitration cycle after n, so vram_wen_o is asserted no earlier than edge n+2.
REQ-027 SHALL, on simultaneous push and pop, leave count_o unchanged; at count_o=DEPTH a same-cycle pop does not raise wr_ready_o that cycle.
REQ-028 SHALL, after a pop, go to IDLE if the queue becomes empty, otherwise PENDING with starve counter 0.
REQ-029 SHALL, with STARVE_LIMIT=1, treat every non-empty cycle as FORCED.

Reset
REQ-030 SHALL, on rst, discard queued entries and return to IDLE: count_o=0, wr_ready_o=1, overflow_o=0, vram_wen_o=0, gpu_grant_o=0, vram_address_o=0, vram_data_o=0, starve counter 0.
REQ-031 SHALL give rst priority over push, pop and arbitration in the same cycle; a write presented during rst is not captured.

Verification
REQ-032 SHALL verify: gpu_req_i=0, push {0x123,0xAB} at edge 0 -> vram_wen_o=1, address 0x123, data 0xAB at edge 2; count_o back to 0.
REQ-033 SHALL verify: gpu_req_i held 1, one write queued, STARVE_LIMIT=8 -> gpu_grant_o=1 for 7 arbitrations, then one write cycle with gpu_grant_o=0, then grants resume.
REQ-034 SHALL verify: DEPTH=4, gpu_req_i=1, 5 back-to-back writes -> wr_ready_o=0 after the 4th, 5th dropped, overflow_o=1; the 4 queued writes drain in order.
REQ-035 SHALL verify: count_o=2, push and pop in the same cycle -> count_o stays 2 and order is preserved across pointer wrap.
REQ-036 SHALL verify: rst asserted with 3 entries queued -> next cycle count_o=0, all outputs at reset values, no stale write ever appears on vram_wen_o.
